logic_unit_pipe: RTL

Parametrised, registered bitwise logic unit: the clocked successor to the single-bit AND/OR/NOT/XOR/NAND gate set.
- Processes WIDTH-bit operands with 8 selectable operations behind a valid/ready handshake.
- Includes a built-in exhaustive sweep engine that drives every (a,b) combination through the selected operation for lab self-test.
- Sits between a stimulus source (switches or testbench) and a result sink (display or checker).

---
 rtl/logic_unit_pkg.sv | 20 ++
 rtl/logic_unit_core.sv | 29 ++
 rtl/logic_unit_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op encodings and sweep FSM states
// for the registered logic unit.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_NOT_A  = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise operation
// selected by a 3-bit op code.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_NOT_A:  y = ~a;
      OP_PASS_A: y = a;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready ports
// and an exhaustive (a,b) sweep engine.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_last
);

  localparam int CW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       sop_q, sop_d;

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;
  logic             last_q, last_d;

  logic             src_valid;
  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             src_last;
  logic [WIDTH-1:0] core_y;
  logic             can_load;
  logic             load;

  always_comb begin
    src_valid = 1'b0;
    src_op    = in_op;
    src_a     = in_a;
    src_b     = in_b;
    src_last  = 1'b0;
    unique case (state_q)
      S_IDLE: src_valid = in_valid;
      S_SWEEP: begin
        src_valid = 1'b1;
        src_op    = sop_q;
        src_a     = cnt_q[CW-1:WIDTH];
        src_b     = cnt_q[WIDTH-1:0];
        src_last  = &cnt_q;
      end
      default: src_valid = 1'b0;
    endcase
  end

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op (src_op),
    .a  (src_a),
    .b  (src_b),
    .y  (core_y)
  );

  assign can_load = !vld_q || out_ready;
  assign load     = src_valid && can_load;
  assign in_ready = (state_q == S_IDLE) && can_load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    unique case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          sop_d   = in_op;
        end
      end
      S_SWEEP: begin
        if (load) begin
          cnt_d = cnt_q + 1'b1;
          if (src_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    y_d    = y_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    zero_d = zero_q;
    par_d  = par_q;
    last_d = last_q;
    if (load) begin
      vld_d  = 1'b1;
      y_d    = core_y;
      op_d   = src_op;
      a_d    = src_a;
      b_d    = src_b;
      zero_d = ~|core_y;
      par_d  = ^core_y;
      last_d = src_last;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sop_q   <= '0;
      vld_q   <= 1'b0;
      y_q     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zero_q  <= 1'b1;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      last_q  <= last_d;
    end
  end

  assign sweep_busy = (state_q == S_SWEEP);
  assign sweep_done = (state_q == S_DONE);
  assign out_valid  = vld_q;
  assign out_y      = y_q;
  assign out_op     = op_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_zero   = zero_q;
  assign out_parity = par_q;
  assign out_last   = last_q;

endmodule
